// File: rtl/ro_sweep_ctrl_pkg.sv
// Shared types and constants for the ring-oscillator sweep controller.
package ro_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN   = 3'd1,
        SETTLE = 3'd2,
        COUNT  = 3'd3,
        REPORT = 3'd4
    } state_t;

    localparam int DEF_N_RO       = 4;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_GATE_W     = 16;
    localparam int DEF_SETTLE_CYC = 8;
    // Two synchronizer flops plus the edge-detector delay must drain in SETTLE.
    localparam int MIN_SETTLE_CYC = 3;

    // Index width for an oscillator bank, never narrower than one bit.
    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/ro_sweep_ctrl_if.sv
// Control/readout bus of ro_sweep_ctrl. The result_ovf wire exists only
// when RO_OVF_FLAG_EN is defined.
interface ro_sweep_ctrl_if
    import ro_ctrl_pkg::*;
#(
    parameter int N_RO   = DEF_N_RO,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int GATE_W = DEF_GATE_W,
    parameter int IDX_W  = idx_width(DEF_N_RO)
);
    logic              start;
    logic              abort;
    logic [N_RO-1:0]   ro_mask;
    logic [GATE_W-1:0] gate_len;
    logic              busy;
    logic              result_valid;
    logic [IDX_W-1:0]  result_idx;
    logic [CNT_W-1:0]  result_cnt;
    logic              done;
`ifdef RO_OVF_FLAG_EN
    logic              result_ovf;
`endif

    modport master (
        output start, abort, ro_mask, gate_len,
`ifdef RO_OVF_FLAG_EN
        input  result_ovf,
`endif
        input  busy, result_valid, result_idx, result_cnt, done
    );

    modport slave (
        input  start, abort, ro_mask, gate_len,
`ifdef RO_OVF_FLAG_EN
        output result_ovf,
`endif
        output busy, result_valid, result_idx, result_cnt, done
    );
endinterface

// File: rtl/ro_edge_sync.sv
// Two-flop synchronizer for an asynchronous oscillator lane followed by a
// rising-edge detector producing a one-clk pulse per captured rising edge.
module ro_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic edge_pulse
);
    logic [2:0] sync;

    // Shift the lane through two metastability flops and one history flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 3'b000;
        end else begin
            sync <= {sync[1:0], din};
        end
    end

    assign edge_pulse = sync[1] & ~sync[2];
endmodule

// File: rtl/ro_sweep_ctrl.sv
// Ring-oscillator sweep sequencer: activates one oscillator at a time,
// settles, counts edges over a gate window, reports one count per lane.
// Optional macro RO_OVF_FLAG_EN: saturating counter plus result_ovf flag.
module ro_sweep_ctrl
    import ro_ctrl_pkg::*;
#(
    parameter int N_RO       = DEF_N_RO,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int GATE_W     = DEF_GATE_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_RO-1:0] ro_in,
    output logic [N_RO-1:0] ro_activate,
    ro_sweep_ctrl_if.slave  bus
);
    localparam int IDX_W = idx_width(N_RO);
    // One extra bit so idx+1 past the last lane cannot alias lane 0.
    localparam int SCN_W = IDX_W + 1;
    localparam logic [GATE_W-1:0] SETTLE_LOAD =
        GATE_W'((SETTLE_CYC < MIN_SETTLE_CYC) ? MIN_SETTLE_CYC - 1 : SETTLE_CYC - 1);

    state_t            state, state_nxt;
    logic [N_RO-1:0]   mask, mask_nxt;
    logic [SCN_W-1:0]  idx, idx_nxt;
    logic [GATE_W-1:0] gate, gate_nxt, tmr, tmr_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              found;
    logic [SCN_W-1:0]  found_idx;
    logic              lane, edge_s;
    logic [N_RO-1:0]   act_nxt, act_r;
    logic              busy_nxt, busy_r, rv_nxt, rv_r, done_nxt, done_r;
    logic [IDX_W-1:0]  ridx_nxt, ridx_r;
    logic [CNT_W-1:0]  rcnt_nxt, rcnt_r;
`ifdef RO_OVF_FLAG_EN
    logic              ovf, ovf_nxt, rovf_nxt, rovf_r;
`endif

    function automatic logic [N_RO-1:0] lane_sel(input logic [SCN_W-1:0] i);
        return N_RO'(1) << i;
    endfunction

    // Lowest remaining mask bit at or above the scan position.
    always_comb begin
        found     = 1'b0;
        found_idx = {SCN_W{1'b0}};
        for (int i = N_RO - 1; i >= 0; i--) begin
            if (mask[i] && (SCN_W'(i) >= idx)) begin
                found     = 1'b1;
                found_idx = SCN_W'(i);
            end else begin
                found     = found;
            end
        end
    end

    // Route the selected oscillator lane into the synchronizer.
    always_comb begin
        if (idx < SCN_W'(N_RO)) begin
            lane = ro_in[idx[IDX_W-1:0]];
        end else begin
            lane = 1'b0;
        end
    end

    ro_edge_sync u_edge_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (lane),
        .edge_pulse (edge_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decision; abort overrides every transition.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (bus.start && !bus.abort) ? SCAN : IDLE;
            SCAN:    state_nxt = found ? SETTLE : IDLE;
            SETTLE:  state_nxt = (tmr == {GATE_W{1'b0}}) ? COUNT : SETTLE;
            COUNT:   state_nxt = (tmr == {GATE_W{1'b0}}) ? REPORT : COUNT;
            REPORT:  state_nxt = SCAN;
            default: state_nxt = IDLE;
        endcase
        if (bus.abort) begin
            state_nxt = IDLE;
        end else begin
            state_nxt = state_nxt;
        end
    end

    // Datapath next values: mask/gate latch, scan index, window timer, counter.
    always_comb begin
        mask_nxt = mask;
        idx_nxt  = idx;
        gate_nxt = gate;
        tmr_nxt  = tmr;
        cnt_nxt  = cnt;
`ifdef RO_OVF_FLAG_EN
        ovf_nxt  = ovf;
`endif
        case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    mask_nxt = bus.ro_mask;
                    gate_nxt = (bus.gate_len == {GATE_W{1'b0}}) ? GATE_W'(1) : bus.gate_len;
                    idx_nxt  = {SCN_W{1'b0}};
                end else begin
                    mask_nxt = mask;
                end
            end
            SCAN: begin
                if (found) begin
                    idx_nxt = found_idx;
                    tmr_nxt = SETTLE_LOAD;
                    cnt_nxt = {CNT_W{1'b0}};
`ifdef RO_OVF_FLAG_EN
                    ovf_nxt = 1'b0;
`endif
                end else begin
                    idx_nxt = idx;
                end
            end
            SETTLE: begin
                if (tmr == {GATE_W{1'b0}}) begin
                    tmr_nxt = gate - GATE_W'(1);
                end else begin
                    tmr_nxt = tmr - GATE_W'(1);
                end
            end
            COUNT: begin
                if (tmr != {GATE_W{1'b0}}) begin
                    tmr_nxt = tmr - GATE_W'(1);
                end else begin
                    tmr_nxt = tmr;
                end
                if (edge_s) begin
`ifdef RO_OVF_FLAG_EN
                    if (cnt == {CNT_W{1'b1}}) begin
                        ovf_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
`else
                    cnt_nxt = cnt + CNT_W'(1);
`endif
                end else begin
                    cnt_nxt = cnt;
                end
            end
            REPORT: begin
                mask_nxt = mask & ~lane_sel(idx);
                idx_nxt  = idx + SCN_W'(1);
            end
            default: begin
                mask_nxt = mask;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= {N_RO{1'b0}};
            idx  <= {SCN_W{1'b0}};
            gate <= {GATE_W{1'b0}};
            tmr  <= {GATE_W{1'b0}};
            cnt  <= {CNT_W{1'b0}};
`ifdef RO_OVF_FLAG_EN
            ovf  <= 1'b0;
`endif
        end else begin
            mask <= mask_nxt;
            idx  <= idx_nxt;
            gate <= gate_nxt;
            tmr  <= tmr_nxt;
            cnt  <= cnt_nxt;
`ifdef RO_OVF_FLAG_EN
            ovf  <= ovf_nxt;
`endif
        end
    end

    // Output decode from the upcoming state so every output is a flop.
    always_comb begin
        busy_nxt = (state_nxt != IDLE);
        rv_nxt   = (state_nxt == REPORT);
        done_nxt = (state == SCAN) && (state_nxt == IDLE) && !bus.abort;
        if ((state_nxt == SETTLE) || (state_nxt == COUNT)) begin
            act_nxt = lane_sel(idx_nxt);
        end else begin
            act_nxt = {N_RO{1'b0}};
        end
        ridx_nxt = rv_nxt ? idx_nxt[IDX_W-1:0] : ridx_r;
        rcnt_nxt = rv_nxt ? cnt_nxt : rcnt_r;
`ifdef RO_OVF_FLAG_EN
        rovf_nxt = rv_nxt ? ovf_nxt : rovf_r;
`endif
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_r  <= {N_RO{1'b0}};
            busy_r <= 1'b0;
            rv_r   <= 1'b0;
            done_r <= 1'b0;
            ridx_r <= {IDX_W{1'b0}};
            rcnt_r <= {CNT_W{1'b0}};
`ifdef RO_OVF_FLAG_EN
            rovf_r <= 1'b0;
`endif
        end else begin
            act_r  <= act_nxt;
            busy_r <= busy_nxt;
            rv_r   <= rv_nxt;
            done_r <= done_nxt;
            ridx_r <= ridx_nxt;
            rcnt_r <= rcnt_nxt;
`ifdef RO_OVF_FLAG_EN
            rovf_r <= rovf_nxt;
`endif
        end
    end

    assign ro_activate      = act_r;
    assign bus.busy         = busy_r;
    assign bus.result_valid = rv_r;
    assign bus.done         = done_r;
    assign bus.result_idx   = ridx_r;
    assign bus.result_cnt   = rcnt_r;
`ifdef RO_OVF_FLAG_EN
    assign bus.result_ovf   = rovf_r;
`endif
endmodule

// File: doc/ro_sweep_ctrl.md
Name: ro_sweep_ctrl

Overview:
Measurement sequencer for a bank of N_RO ring-oscillator tiles. It activates one oscillator at a time and waits a settle window. It then counts rising edges of that oscillator's (pre-divided) output over a programmable gate window in the clk domain, and reports one count per oscillator. It sits between the tile's control/readout logic and the ring_osc instances, and is the sole driver of every ro_activate input.

Parameters:
N_RO, 4, number of oscillators swept; IDX_W = $clog2(N_RO), minimum 1
CNT_W, 16, edge-counter / result width
GATE_W, 16, width of gate_len
SETTLE_CYC, 8, clk cycles between activation and start of counting (minimum 3)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle sweep request; honoured only in IDLE
abort  in  1  cancel sweep; dominates start
ro_mask  in  N_RO  oscillators included in the sweep; sampled on accepted start
gate_len  in  GATE_W  count window in clk cycles; sampled on accepted start; 0 treated as 1
ro_in  in  N_RO  per-oscillator divided outputs, asynchronous to clk
ro_activate  out  N_RO  one-hot-or-zero enable to ring_osc instances
busy  out  1  high in every non-IDLE state
result_valid  out  1  one-cycle pulse per measured oscillator
result_idx  out  IDX_W  index of the reported oscillator
result_cnt  out  CNT_W  rising-edge count for result_idx
done  out  1  one-cycle pulse at sweep end (not on abort)

Behaviour:
- Reset: state IDLE. ro_activate, busy, result_valid, done = 0. result_idx, result_cnt, counters and synchronizer flops = 0.
- All outputs are registered. At most one ro_activate bit is high in any cycle.
- IDLE -> SCAN on start && !abort. Latch ro_mask and gate_len; idx = 0.
- SCAN (1 cycle): find the lowest set mask bit >= idx.
  - If found: idx = that bit, go to SETTLE.
  - If none: go to IDLE and pulse done the same cycle IDLE is entered.
  - ro_mask = 0: done pulses 2 cycles after start, with no results.
- SETTLE: ro_activate[idx] = 1 for SETTLE_CYC cycles.
  - The selected ro_in lane is muxed, then passed through a 2-flop synchronizer and a rising-edge detector; SETTLE flushes this path.
  - Edge counter is cleared on SETTLE entry.
- COUNT: ro_activate[idx] stays high for exactly max(gate_len,1) cycles. The counter increments on each detected rising edge in these cycles. Counter width is CNT_W and it wraps modulo 2^CNT_W.
- REPORT (1 cycle): ro_activate = 0. result_valid = 1, result_idx = idx, result_cnt = counter. Clear the mask bit and go to SCAN with idx+1.
  - Clearing idx N_RO-1 means SCAN finds nothing and the sweep ends.
- result_idx / result_cnt hold their values until the next REPORT.
- start while busy: ignored.
- abort in any state: next cycle state = IDLE, ro_activate = 0, busy = 0. No result_valid or done is issued for the aborted oscillator. start and abort in the same cycle in IDLE: no sweep.
- Reset mid-sweep: all outputs return to reset values asynchronously; no pulses follow.
- Counts are only meaningful when the divided RO frequency is < clk/2. The block does not check this.

Optional Feature:
RO_OVF_FLAG_EN
- Defined: the counter saturates at 2^CNT_W-1. An extra output port result_ovf (1 bit) is added, valid with result_valid, high if saturation occurred during that COUNT window; reset 0.
- Undefined: the counter wraps and the result_ovf port does not exist.

Decomposition:
- Package ro_ctrl_pkg holds:
  - state enum: IDLE, SCAN, SETTLE, COUNT, REPORT
  - default parameter constants
  - minimum SETTLE_CYC constant
- Sub-module ro_edge_sync: 2-flop synchronizer plus rising-edge detector, async active-low reset, output edge_pulse. Instantiated once after the lane mux.

Test Plan:
- Reset held, then released with no start -> all outputs 0, state IDLE for 50 cycles.
- ro_mask=4'b0101, gate_len=100, SETTLE_CYC=8; bench toggles ro_in[0] every 2 clk (period 4) and ro_in[2] every 5 clk (period 10) -> result_valid twice: idx 0 cnt 25, then idx 2 cnt 10; done 1 cycle after second REPORT; ro_activate[1] and [3] never high.
- ro_mask=0, start -> done pulses exactly 2 cycles after start; no result_valid; busy high for 1 cycle.
- Sweep mask 4'b1111, assert abort during COUNT of idx 1 -> ro_activate=0 next cycle; exactly one result (idx 0); no done; new start then runs a full sweep of 4.
- gate_len=0 with ro_in[3] period 2 -> COUNT lasts 1 cycle; result_cnt in {0,1}. Also pulse start while busy -> ignored, sweep length unchanged.
- RO_OVF_FLAG_EN with CNT_W=4, gate_len=100, period 4 -> result_cnt=15, result_ovf=1. Without the macro, same stimulus -> result_cnt=25 mod 16 = 9.
